// File: rtl/cfg_dispatcher_if.sv
// Host packet bus and accelerator configuration bus for cfg_dispatcher.
// The slave modport is the dispatcher side; master is the host/accelerator side.
interface cfg_dispatcher_if #(
   parameter int POST_CWIDTH = 16,
   parameter int TMPC_CWIDTH = 16,
   parameter int WICP_CWIDTH = 16,
   parameter int DATA_CWIDTH = 32,
   parameter int DEPTH       = 8,
   parameter int CNT_WIDTH   = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [POST_CWIDTH-1:0]     in_post;
   logic [TMPC_CWIDTH-1:0]     in_tmpc;
   logic [WICP_CWIDTH-1:0]     in_wicp;
   logic [DATA_CWIDTH-1:0]     in_data;
   logic                       cfg_valid;
   logic                       cfg_busy;
   logic [POST_CWIDTH-1:0]     cfg_post_data;
   logic [TMPC_CWIDTH-1:0]     cfg_tmpc_data;
   logic [WICP_CWIDTH-1:0]     cfg_wicp_data;
   logic [DATA_CWIDTH-1:0]     cfg_data_data;
   logic [$clog2(DEPTH):0]     fifo_level;
   logic [CNT_WIDTH-1:0]       done_cnt;
   logic                       timeout_err;
   logic                       err_clr;
   logic                       idle;

   modport slave (
      input  in_valid, in_post, in_tmpc, in_wicp, in_data, cfg_busy, err_clr,
      output in_ready, cfg_valid, cfg_post_data, cfg_tmpc_data, cfg_wicp_data,
             cfg_data_data, fifo_level, done_cnt, timeout_err, idle
   );

   modport master (
      output in_valid, in_post, in_tmpc, in_wicp, in_data, cfg_busy, err_clr,
      input  in_ready, cfg_valid, cfg_post_data, cfg_tmpc_data, cfg_wicp_data,
             cfg_data_data, fifo_level, done_cnt, timeout_err, idle
   );
endinterface

// File: rtl/cfg_dispatcher.sv
// Buffers host configuration packets and issues them one at a time to an idle
// PE-array accelerator, tracking issue / busy-rise / busy-fall per command.
module cfg_dispatcher #(
   parameter int POST_CWIDTH = 16,
   parameter int TMPC_CWIDTH = 16,
   parameter int WICP_CWIDTH = 16,
   parameter int DATA_CWIDTH = 32,
   parameter int DEPTH       = 8,
   parameter int ACK_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 16
) (
   input logic             clk,
   input logic             rst,
   cfg_dispatcher_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;
   localparam int PKT_W = POST_CWIDTH + TMPC_CWIDTH + WICP_CWIDTH + DATA_CWIDTH;

   typedef enum logic [1:0] {IDLE, ISSUE, ACK, RUN} state_t;

   state_t               r_state, w_state_nxt;
   logic [PKT_W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]     r_level;
   logic [ACK_W-1:0]     r_ack_cnt, w_ack_nxt;
   logic                 r_cfg_valid;
   logic [PKT_W-1:0]     r_cfg_pkt;
   logic [CNT_WIDTH-1:0] r_done_cnt;
   logic                 r_timeout_err;
   logic [PKT_W-1:0]     w_in_pkt;
   logic                 w_full, w_push, w_pop, w_done, w_timeout;

   assign w_in_pkt  = {bus.in_post, bus.in_tmpc, bus.in_wicp, bus.in_data};
   assign w_full    = (r_level == LVL_W'(DEPTH));
   assign w_push    = bus.in_valid && !w_full;
   assign w_ack_nxt = r_ack_cnt + ACK_W'(1);

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            // Pop decision uses the registered level: a fresh push waits one cycle.
            if (r_level != '0 && !bus.cfg_busy) begin
               w_pop       = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: w_state_nxt = ACK;
         ACK: begin
            if (bus.cfg_busy) begin
               w_state_nxt = RUN;
            end else if (w_ack_nxt == ACK_W'(ACK_TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (!bus.cfg_busy) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: packet storage has no reset; validity is carried entirely by the pointers and level.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_pkt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_cfg_valid   <= 1'b0;
         r_cfg_pkt     <= '0;
         r_ack_cnt     <= '0;
         r_done_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_cfg_valid <= w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_cfg_pkt <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: ;
         endcase
         if (r_state == ISSUE)                     r_ack_cnt <= '0;
         else if (r_state == ACK && !bus.cfg_busy) r_ack_cnt <= w_ack_nxt;
         if (w_done) r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);
         // A timeout in the same cycle as err_clr keeps the flag set.
         if (w_timeout)        r_timeout_err <= 1'b1;
         else if (bus.err_clr) r_timeout_err <= 1'b0;
      end
   end

   assign bus.in_ready    = !w_full;
   assign bus.cfg_valid   = r_cfg_valid;
   assign {bus.cfg_post_data, bus.cfg_tmpc_data, bus.cfg_wicp_data, bus.cfg_data_data} = r_cfg_pkt;
   assign bus.fifo_level  = r_level;
   assign bus.done_cnt    = r_done_cnt;
   assign bus.timeout_err = r_timeout_err;
   assign bus.idle        = (r_state == IDLE) && (r_level == '0);
endmodule

// File: tb/tb_cfg_dispatcher.sv
// Directed self-checking bench for cfg_dispatcher: latency, full FIFO, ack
// timeout, push/pop overlap with pointer wrap, reset mid-command, busy in IDLE.
module tb_cfg_dispatcher;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [15:0] post;
      logic [15:0] tmpc;
      logic [15:0] wicp;
      logic [31:0] data;
   } pkt_t;

   logic clk, rst;
   logic man_busy, auto_busy, auto_en;
   int   auto_left;
   int   n_checks, n_errors;
   pkt_t issued[$];

   cfg_dispatcher_if #(.CNT_WIDTH(CNT_W)) bus ();

   cfg_dispatcher #(.CNT_WIDTH(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.cfg_busy = man_busy | auto_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accelerator model: after seeing an issue, raise busy for three cycles.
   initial begin
      auto_busy = 1'b0;
      auto_left = 0;
      forever begin
         @(negedge clk);
         if (!auto_en) begin
            auto_busy = 1'b0;
            auto_left = 0;
         end else if (auto_left != 0) begin
            auto_busy = 1'b1;
            auto_left--;
         end else begin
            auto_busy = 1'b0;
            if (bus.cfg_valid) auto_left = 3;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && bus.cfg_valid)
         issued.push_back({bus.cfg_post_data, bus.cfg_tmpc_data, bus.cfg_wicp_data, bus.cfg_data_data});
   end

   function automatic pkt_t mk_pkt(input int i);
      pkt_t p;
      p.post = 16'h0100 + 16'(i);
      p.tmpc = 16'h0200 + 16'(i);
      p.wicp = 16'h0300 + 16'(i);
      p.data = 32'hC0DE_0000 + 32'(i);
      return p;
   endfunction

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_pkt(input pkt_t p);
      bus.in_post = p.post;
      bus.in_tmpc = p.tmpc;
      bus.in_wicp = p.wicp;
      bus.in_data = p.data;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.err_clr  = 1'b0;
      man_busy     = 1'b0;
      auto_en      = 1'b0;
      step(2);
      rst = 1'b0;
      issued.delete();
   endtask

   task automatic wait_issued(input int n, input int bound);
      int cyc = 0;
      while (!(issued.size() >= n && bus.idle) && cyc < bound) begin
         step(1);
         cyc++;
      end
      check("wait_issued", 80'(issued.size()), 80'(n));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      drive_pkt('0);
      do_reset();

      // Reset state
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_idle", bus.idle, 1);
      check("rst_level", bus.fifo_level, 0);
      check("rst_done", bus.done_cnt, 0);
      check("rst_tmo", bus.timeout_err, 0);
      check("rst_valid", bus.cfg_valid, 0);
      check("rst_data", bus.cfg_data_data, 0);

      // Single packet: issue latency and busy handshake
      bus.in_valid = 1'b1;
      bus.in_post = 16'h11; bus.in_tmpc = 16'h22; bus.in_wicp = 16'h33; bus.in_data = 32'hDEADBEEF;
      step();                                   // edge t: push
      bus.in_valid = 1'b0;
      check("t0_level", bus.fifo_level, 1);
      check("t0_valid", bus.cfg_valid, 0);
      step();                                   // edge t+1: pop
      check("t1_valid", bus.cfg_valid, 1);
      check("t1_post", bus.cfg_post_data, 16'h11);
      check("t1_tmpc", bus.cfg_tmpc_data, 16'h22);
      check("t1_wicp", bus.cfg_wicp_data, 16'h33);
      check("t1_data", bus.cfg_data_data, 32'hDEADBEEF);
      check("t1_level", bus.fifo_level, 0);
      step();                                   // edge t+2
      check("t2_valid", bus.cfg_valid, 0);
      step();                                   // edge t+3
      man_busy = 1'b1;
      step(5);                                  // busy sampled high at t+4..t+8
      check("run_done", bus.done_cnt, 0);
      check("run_idle", bus.idle, 0);
      man_busy = 1'b0;
      step();                                   // edge t+9: busy fall
      check("fall_done", bus.done_cnt, 1);
      check("fall_idle", bus.idle, 1);
      check("hold_data", bus.cfg_data_data, 32'hDEADBEEF);

      // Fill past DEPTH with the accelerator stalled busy, then drain
      do_reset();
      man_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 8) check("full_ready", bus.in_ready, 0);
         bus.in_valid = 1'b1;
         drive_pkt(mk_pkt(i));
         step();
      end
      bus.in_valid = 1'b0;
      check("full_level", bus.fifo_level, 8);
      check("full_valid", 80'(issued.size()), 0);
      man_busy = 1'b0;
      auto_en  = 1'b1;
      wait_issued(8, 200);
      for (int i = 0; i < 8 && i < issued.size(); i++)
         check($sformatf("drain_pkt%0d", i), issued[i], mk_pkt(i));
      check("drain_done", bus.done_cnt, 8);
      check("drain_tmo", bus.timeout_err, 0);

      // Acknowledge timeout, sticky flag, clear, and set-wins-over-clear
      do_reset();
      bus.in_valid = 1'b1;
      drive_pkt(mk_pkt(40));
      step();
      bus.in_valid = 1'b0;
      step();                                   // edge a: ISSUE
      check("tmo_issue", bus.cfg_valid, 1);
      step(15);
      check("tmo_early", bus.timeout_err, 0);
      check("tmo_early_done", bus.done_cnt, 0);
      step();                                   // edge a+16
      check("tmo_set", bus.timeout_err, 1);
      check("tmo_done", bus.done_cnt, 1);
      check("tmo_idle", bus.idle, 1);
      auto_en      = 1'b1;
      bus.in_valid = 1'b1;
      drive_pkt(mk_pkt(41));
      step();
      bus.in_valid = 1'b0;
      wait_issued(2, 100);
      check("tmo_next_pkt", issued[issued.size()-1], mk_pkt(41));
      check("tmo_next_done", bus.done_cnt, 2);
      check("tmo_sticky", bus.timeout_err, 1);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("tmo_clr", bus.timeout_err, 0);
      auto_en      = 1'b0;
      bus.in_valid = 1'b1;
      drive_pkt(mk_pkt(42));
      step();
      bus.in_valid = 1'b0;
      step();                                   // edge a: ISSUE
      step(15);
      check("tmo_pre_clr", bus.timeout_err, 0);
      bus.err_clr = 1'b1;
      step();                                   // timeout and clear on the same edge
      bus.err_clr = 1'b0;
      check("tmo_set_wins", bus.timeout_err, 1);
      check("tmo_done3", bus.done_cnt, 3);

      // Simultaneous push/pop at level 3, then 20 packets through the wrap
      do_reset();
      man_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         drive_pkt(mk_pkt(i));
         step();
      end
      check("pp_level3", bus.fifo_level, 3);
      issued.delete();
      man_busy = 1'b0;
      auto_en  = 1'b1;
      drive_pkt(mk_pkt(3));
      step();                                   // push pkt3 and pop pkt0 together
      check("pp_level_same", bus.fifo_level, 3);
      check("pp_valid", bus.cfg_valid, 1);
      begin
         int  nxt = 4;
         int  cyc = 0;
         logic acc;
         while ((nxt < 20 || issued.size() < 20 || !bus.idle) && cyc < 2000) begin
            if (nxt < 20) begin
               bus.in_valid = 1'b1;
               drive_pkt(mk_pkt(nxt));
            end else begin
               bus.in_valid = 1'b0;
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (acc) nxt++;
         end
      end
      bus.in_valid = 1'b0;
      check("wrap_count", 80'(issued.size()), 20);
      for (int i = 0; i < 20 && i < issued.size(); i++)
         check($sformatf("wrap_pkt%0d", i), issued[i], mk_pkt(i));
      check("wrap_done", bus.done_cnt, 4);    // 20 completions in a 4-bit counter

      // Reset while RUN with four packets queued
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i == 3) man_busy = 1'b1;
         bus.in_valid = 1'b1;
         drive_pkt(mk_pkt(50 + i));
         step();
      end
      bus.in_valid = 1'b0;
      check("mid_level", bus.fifo_level, 4);
      check("mid_idle", bus.idle, 0);
      check("mid_done", bus.done_cnt, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_valid", bus.cfg_valid, 0);
      check("mrst_level", bus.fifo_level, 0);
      check("mrst_done", bus.done_cnt, 0);
      check("mrst_idle", bus.idle, 1);
      check("mrst_ready", bus.in_ready, 1);
      check("mrst_data", bus.cfg_data_data, 0);
      man_busy = 1'b0;
      issued.delete();
      step(10);
      check("mrst_no_issue", 80'(issued.size()), 0);

      // External busy in IDLE blocks issue
      man_busy     = 1'b1;
      bus.in_valid = 1'b1;
      drive_pkt(mk_pkt(30));
      step();
      bus.in_valid = 1'b0;
      step(3);
      check("blk_valid", bus.cfg_valid, 0);
      check("blk_issued", 80'(issued.size()), 0);
      check("blk_level", bus.fifo_level, 1);
      check("blk_tmo", bus.timeout_err, 0);
      man_busy = 1'b0;
      step();
      check("unblk_valid", bus.cfg_valid, 1);
      check("unblk_data", bus.cfg_data_data, mk_pkt(30).data);
      check("unblk_level", bus.fifo_level, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
